// File: rtl/shift_seq_pkg.sv
// shift_seq_pkg: shared op codes, FSM states and remaining-count width for the shift sequencer
package shift_seq_pkg;
  localparam logic [1:0] SLL = 2'b00;
  localparam logic [1:0] SRL = 2'b01;
  localparam logic [1:0] SRA = 2'b11;
  localparam int REM_W = 6;
  typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
endpackage

// File: rtl/shift_seq_ctrl_if.sv
// shift_seq_ctrl_if: issue-side request/result bundle for the multi-cycle shift sequencer
interface shift_seq_ctrl_if #(parameter int XLEN = 32);
  logic            req_valid;
  logic            req_ready;
  logic [XLEN-1:0] src1;
  logic [4:0]      src2;
  logic            funct3_2;
  logic            funct7_5;
  logic            flush;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] result;
  modport master (output req_valid, src1, src2, funct3_2, funct7_5, flush, input req_ready, busy, done, result);
  modport slave (input req_valid, src1, src2, funct3_2, funct7_5, flush, output req_ready, busy, done, result);
endinterface

// File: rtl/shift_step.sv
// shift_step: combinational shift of the accumulator by 0..STEP positions, sign fill for SRA
module shift_step import shift_seq_pkg::*; #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input  logic [XLEN-1:0]            acc,
  input  logic [$clog2(STEP+1)-1:0]  amt,
  input  logic [1:0]                 op,
  output logic [XLEN-1:0]            shifted
);
  logic signed [XLEN-1:0] sra;
  // kept separate so the arithmetic shift stays signed regardless of the select below
  assign sra = $signed(acc) >>> amt;
  assign shifted = op == SLL ? acc << amt : op == SRA ? sra : acc >> amt;
endmodule

// File: rtl/shift_seq_ctrl.sv
// shift_seq_ctrl: multi-cycle SLL/SRL/SRA sequencer, up to STEP positions per clock; SHIFT_EARLY_EXIT_EN enables saturation exit
module shift_seq_ctrl import shift_seq_pkg::*; #(
  parameter int XLEN = 32,
  parameter int STEP = 4
) (
  input logic             clk,
  input logic             rst_n,
  shift_seq_ctrl_if.slave bus
);
  localparam int AW = $clog2(STEP + 1);
  state_t state, state_n;
  logic [XLEN-1:0]  acc, acc_n, stepped, result;
  logic [REM_W-1:0] rem, rem_n;
  logic [1:0]       op, op_n, op_in;
  logic [AW-1:0]    amt;
  logic             accept, illegal, sat;
  assign op_in   = {bus.funct7_5, bus.funct3_2};
  assign illegal = op_in == 2'b10;
  assign accept  = bus.req_valid & bus.req_ready & ~bus.flush;
  assign amt     = rem < REM_W'(STEP) ? rem[AW-1:0] : AW'(STEP);
`ifdef SHIFT_EARLY_EXIT_EN
  // further shifting cannot change an all-zero or all-sign accumulator
  assign sat = op == SRA ? acc == {XLEN{acc[XLEN-1]}} : acc == '0;
`else
  assign sat = 1'b0;
`endif
  shift_step #(.XLEN(XLEN), .STEP(STEP)) u_step (.acc(acc), .amt(amt), .op(op), .shifted(stepped));
  always_comb begin
    state_n = state;
    acc_n   = acc;
    rem_n   = rem;
    op_n    = op;
    unique case (state)
      IDLE: if (accept) begin
        op_n    = op_in;
        acc_n   = illegal ? '0 : bus.src1;
        rem_n   = REM_W'(bus.src2);
        state_n = illegal || bus.src2 == 5'd0 ? DONE : SHIFT;
      end
      SHIFT: if (bus.flush) state_n = IDLE;
        else if (sat) state_n = DONE;
        else begin
          acc_n   = stepped;
          rem_n   = rem - REM_W'(amt);
          state_n = rem_n == '0 ? DONE : SHIFT;
        end
      default: state_n = IDLE;
    endcase
  end
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      acc    <= '0;
      rem    <= '0;
      op     <= SLL;
      result <= '0;
    end else begin
      state <= state_n;
      acc   <= acc_n;
      rem   <= rem_n;
      op    <= op_n;
      if (state_n == DONE) result <= acc_n;
    end
  end
  assign bus.req_ready = state == IDLE;
  assign bus.busy      = state != IDLE;
  assign bus.done      = state == DONE && !bus.flush;
  assign bus.result    = result;
endmodule
